// File: rtl/dii_package.sv
// Shared debug-interconnect flit types used by the ring link and its channel FIFOs.
package dii_package;

  localparam int DII_DATA_WIDTH = 16;

  typedef struct packed {
    logic                      valid;
    logic                      last;
    logic [DII_DATA_WIDTH-1:0] data;
  } dii_flit;

  // What a FIFO slot holds: valid is implied by occupancy.
  typedef struct packed {
    logic                      last;
    logic [DII_DATA_WIDTH-1:0] data;
  } dii_payload;

endpackage

// File: rtl/dii_link_fifo.sv
// Single-channel registered FIFO between two ring segments, with occupancy,
// forwarded-packet counter and in-packet tracking on the output side.
module dii_link_fifo
  import dii_package::*;
#(
  parameter int BUFFER_SIZE = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  dii_flit                            i_in,
  output logic                               o_in_ready,
  output dii_flit                            o_out,
  input  logic                               i_out_ready,
  output logic [$clog2(BUFFER_SIZE+1)-1:0]   o_count,
  output logic [CNT_WIDTH-1:0]               o_pkt_cnt,
  output logic                               o_in_packet
);

  localparam int PTR_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
  localparam int CNT_W = $clog2(BUFFER_SIZE + 1);

  dii_payload           r_mem [BUFFER_SIZE];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic [CNT_WIDTH-1:0] r_pkt_cnt;
  logic                 r_in_packet;

  logic       w_not_empty;
  logic       w_in_ready;
  logic       w_push;
  logic       w_pop;
  dii_payload w_head;

  // Pointers wrap modulo BUFFER_SIZE, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUFFER_SIZE - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_not_empty = (r_count != '0);
  assign w_in_ready  = !rst && (r_count < CNT_W'(BUFFER_SIZE));
  assign w_push      = i_in.valid && w_in_ready;
  assign w_pop       = w_not_empty && i_out_ready;
  assign w_head      = r_mem[r_rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pkt_cnt   <= '0;
      r_in_packet <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);

      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      if (w_pop) begin
        r_in_packet <= !w_head.last;
        if (w_head.last) r_pkt_cnt <= r_pkt_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // NOTE: the storage array has no reset; occupancy gates every read, so stale
  // contents are never visible and the array can map to plain flops or RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{last: i_in.last, data: i_in.data};
  end

  // NOTE: combinational outputs get a full default first so no latch is inferred.
  always_comb begin
    o_out = '0;
    if (w_not_empty) begin
      o_out.valid = 1'b1;
      o_out.last  = w_head.last;
      o_out.data  = w_head.data;
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_count     = r_count;
  assign o_pkt_cnt   = r_pkt_cnt;
  assign o_in_packet = r_in_packet;

endmodule

// File: rtl/debug_ring_link.sv
// Two-channel elastic link joining the extension ports of two debug ring
// segments; each ring channel gets its own independent registered FIFO.
module debug_ring_link
  import dii_package::*;
#(
  parameter int BUFFER_SIZE = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  dii_flit [1:0]                          up_in,
  output logic    [1:0]                          up_in_ready,
  output dii_flit [1:0]                          down_out,
  input  logic    [1:0]                          down_out_ready,
  output logic    [1:0][$clog2(BUFFER_SIZE+1)-1:0] fill_level,
  output logic    [1:0][CNT_WIDTH-1:0]           pkt_cnt,
  output logic    [1:0]                          in_packet
);

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    dii_link_fifo #(
      .BUFFER_SIZE (BUFFER_SIZE),
      .CNT_WIDTH   (CNT_WIDTH)
    ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_in        (up_in[ch]),
      .o_in_ready  (up_in_ready[ch]),
      .o_out       (down_out[ch]),
      .i_out_ready (down_out_ready[ch]),
      .o_count     (fill_level[ch]),
      .o_pkt_cnt   (pkt_cnt[ch]),
      .o_in_packet (in_packet[ch])
    );
  end

endmodule

// File: tb/tb_debug_ring_link.sv
// Bench for debug_ring_link: queue model per channel checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_debug_ring_link;
  import dii_package::*;

  localparam int BS = 4;
  localparam int CW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  dii_flit [1:0]        up_in;
  logic    [1:0]        up_in_ready;
  dii_flit [1:0]        down_out;
  logic    [1:0]        down_out_ready;
  logic    [1:0][2:0]   fill_level;
  logic    [1:0][CW-1:0] pkt_cnt;
  logic    [1:0]        in_packet;

  debug_ring_link #(.BUFFER_SIZE(BS), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .up_in          (up_in),
    .up_in_ready    (up_in_ready),
    .down_out       (down_out),
    .down_out_ready (down_out_ready),
    .fill_level     (fill_level),
    .pkt_cnt        (pkt_cnt),
    .in_packet      (in_packet)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each channel is just an ordered queue of {last,data} of at most BS entries.
  logic [16:0]   m_q [2][$];
  logic [CW-1:0] m_pkt [2];
  bit            m_inpkt [2];
  bit            model_live = 1'b0;

  always @(posedge clk) begin
    model_live = 1'b1;
    for (int ch = 0; ch < 2; ch++) begin
      if (rst) begin
        m_q[ch].delete();
        m_pkt[ch]   = '0;
        m_inpkt[ch] = 1'b0;
      end else begin
        bit          room;
        bit          pop;
        logic [16:0] f;
        room = (m_q[ch].size() < BS);
        pop  = (m_q[ch].size() != 0) && down_out_ready[ch];
        if (pop) begin
          f = m_q[ch].pop_front();
          if (f[16]) m_pkt[ch] = m_pkt[ch] + 1'b1;
          m_inpkt[ch] = !f[16];
        end
        if (up_in[ch].valid && room) m_q[ch].push_back({up_in[ch].last, up_in[ch].data});
      end
    end
  end

  dii_flit prev_out [2];
  bit      prev_stall [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    if (model_live) begin
      for (int ch = 0; ch < 2; ch++) begin
        int sz;
        sz = m_q[ch].size();
        check($sformatf("ch%0d valid", ch), 32'(down_out[ch].valid), 32'(sz != 0));
        if (sz != 0) begin
          check($sformatf("ch%0d data", ch), 32'(down_out[ch].data), 32'(m_q[ch][0][15:0]));
          check($sformatf("ch%0d last", ch), 32'(down_out[ch].last), 32'(m_q[ch][0][16]));
        end
        check($sformatf("ch%0d ready", ch), 32'(up_in_ready[ch]), 32'(!rst && sz < BS));
        check($sformatf("ch%0d fill", ch), 32'(fill_level[ch]), 32'(sz));
        check($sformatf("ch%0d fill_bound", ch), 32'(fill_level[ch] <= 3'(BS)), 32'd1);
        check($sformatf("ch%0d pkt_cnt", ch), 32'(pkt_cnt[ch]), 32'(m_pkt[ch]));
        check($sformatf("ch%0d in_packet", ch), 32'(in_packet[ch]), 32'(m_inpkt[ch]));
        if (prev_stall[ch])
          check($sformatf("ch%0d stall_hold", ch), 32'(down_out[ch]), 32'(prev_out[ch]));
        prev_stall[ch] = down_out[ch].valid && !down_out_ready[ch] && !rst;
        prev_out[ch]   = down_out[ch];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input bit v, input bit l, input logic [15:0] d);
    up_in[ch].valid = v;
    up_in[ch].last  = l;
    up_in[ch].data  = d;
  endtask

  int accepted;
  int inpkt_cycles;

  initial begin
    rst            = 1'b1;
    up_in          = '0;
    down_out_ready = 2'b00;

    // Reset state
    repeat (2) tick();
    check("rst ready", 32'(up_in_ready), 32'h0);
    check("rst valid", 32'({down_out[1].valid, down_out[0].valid}), 32'h0);
    check("rst data0", 32'(down_out[0].data), 32'h0);
    check("rst last0", 32'(down_out[0].last), 32'h0);
    check("rst fill", 32'(fill_level), 32'h0);
    check("rst pkt", 32'(pkt_cnt), 32'h0);
    check("rst in_packet", 32'(in_packet), 32'h0);
    rst = 1'b0;
    #1;
    check("post-rst ready", 32'(up_in_ready), 32'h3);

    // Single flit on channel 0
    down_out_ready = 2'b11;
    drive(0, 1'b1, 1'b1, 16'hA5A5);
    tick();
    drive(0, 1'b0, 1'b0, 16'h0);
    check("single valid", 32'(down_out[0].valid), 32'h1);
    check("single data", 32'(down_out[0].data), 32'hA5A5);
    check("single fill", 32'(fill_level[0]), 32'h1);
    check("single ch1 idle", 32'(down_out[1].valid), 32'h0);
    tick();
    check("single drained", 32'(down_out[0].valid), 32'h0);
    check("single fill0", 32'(fill_level[0]), 32'h0);
    check("single pkt", 32'(pkt_cnt[0]), 32'h1);

    // Fill and backpressure on channel 1
    down_out_ready[1] = 1'b0;
    accepted = 0;
    for (int k = 0; k < 6; k++) begin
      drive(1, 1'b1, 1'b1, 16'h1000 + 16'(k));
      #1;
      if (up_in_ready[1]) accepted++;
      tick();
    end
    drive(1, 1'b0, 1'b0, 16'h0);
    check("bp accepted", 32'(accepted), 32'd4);
    check("bp ready", 32'(up_in_ready[1]), 32'h0);
    check("bp fill", 32'(fill_level[1]), 32'd4);
    down_out_ready[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp order %0d", k), 32'(down_out[1].data), 32'h1000 + 32'(k));
      check($sformatf("bp ready %0d", k), 32'(up_in_ready[1]), 32'(k != 0));
      tick();
    end
    check("bp drained", 32'(down_out[1].valid), 32'h0);
    check("bp pkt", 32'(pkt_cnt[1]), 32'd4);

    // Streaming 3-flit packet on channel 0
    inpkt_cycles = 0;
    drive(0, 1'b1, 1'b0, 16'h0001);
    tick();
    check("stream f1", 32'(down_out[0].data), 32'h0001);
    inpkt_cycles += int'(in_packet[0]);
    drive(0, 1'b1, 1'b0, 16'h0002);
    tick();
    check("stream f2", 32'(down_out[0].data), 32'h0002);
    check("stream fill", 32'(fill_level[0]), 32'h1);
    inpkt_cycles += int'(in_packet[0]);
    drive(0, 1'b1, 1'b1, 16'h0003);
    tick();
    check("stream f3", 32'({down_out[0].last, down_out[0].data}), 32'h10003);
    inpkt_cycles += int'(in_packet[0]);
    drive(0, 1'b0, 1'b0, 16'h0);
    tick();
    inpkt_cycles += int'(in_packet[0]);
    check("stream in_packet cycles", 32'(inpkt_cycles), 32'd2);
    check("stream pkt", 32'(pkt_cnt[0]), 32'd2);
    check("stream empty", 32'(down_out[0].valid), 32'h0);

    // Mid-packet reset
    drive(0, 1'b1, 1'b0, 16'h0011);
    tick();
    drive(0, 1'b1, 1'b0, 16'h0012);
    tick();
    check("mid in_packet", 32'(in_packet[0]), 32'h1);
    check("mid fill", 32'(fill_level[0]), 32'h1);
    drive(0, 1'b0, 1'b0, 16'h0);
    rst = 1'b1;
    #1;
    check("mid ready low", 32'(up_in_ready), 32'h0);
    tick();
    check("mid valid", 32'({down_out[1].valid, down_out[0].valid}), 32'h0);
    check("mid fill0", 32'(fill_level), 32'h0);
    check("mid in_packet0", 32'(in_packet), 32'h0);
    check("mid pkt0", 32'(pkt_cnt), 32'h0);
    rst = 1'b0;
    #1;
    check("mid ready back", 32'(up_in_ready), 32'h3);

    // Random valid/ready on both channels
    for (int c = 0; c < 10000; c++) begin
      for (int ch = 0; ch < 2; ch++) begin
        drive(ch, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 16'($urandom));
        down_out_ready[ch] = ($urandom_range(0, 9) < 6);
      end
      tick();
    end
    up_in          = '0;
    down_out_ready = 2'b11;
    repeat (6) tick();
    check("rand drained", 32'(fill_level), 32'h0);

    // Packet counter wrap on channel 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      drive(0, 1'b1, 1'b1, 16'(i));
      tick();
    end
    drive(0, 1'b0, 1'b0, 16'h0);
    tick();
    check("wrap max", 32'(pkt_cnt[0]), 32'hFFFF);
    drive(0, 1'b1, 1'b1, 16'hBEEF);
    tick();
    drive(0, 1'b0, 1'b0, 16'h0);
    tick();
    check("wrap zero", 32'(pkt_cnt[0]), 32'h0);
    check("wrap ch1 untouched", 32'(pkt_cnt[1]), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
